// File: rtl/conv_pkg.sv
// Shared definitions for the convolution frame loader: FSM encoding and byte counts.
package conv_pkg;

  typedef enum logic [1:0] {
    LOAD_W  = 2'd0,
    LOAD_F  = 2'd1,
    PRESENT = 2'd2
  } state_t;

  localparam int KS_DEF  = 3;
  localparam int IMG_DEF = 5;
  localparam int NW      = KS_DEF * KS_DEF;
  localparam int NP      = IMG_DEF * IMG_DEF;

  // Bytes in a square block of the given side length.
  function automatic int byte_count(input int side);
    return side * side;
  endfunction

  // Counter width able to index the larger of the two phases.
  function automatic int cnt_bits(input int nw, input int np);
    int mx;
    mx = (nw > np) ? nw : np;
    return (mx < 2) ? 1 : $clog2(mx);
  endfunction

endpackage

// File: rtl/conv_frame_loader.sv
// Streams a kernel then an image into packed registers and presents them to the
// convolution stage. Handshake: a byte moves on a rising edge with in_valid && in_ready.
module conv_frame_loader
  import conv_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int IMG   = IMG_DEF,
  parameter int KS    = KS_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PIX_W-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       reload_w,
  output logic [IMG*IMG*PIX_W-1:0]   f,
  output logic [KS*KS*PIX_W-1:0]     w,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       w_loaded,
  output logic [1:0]                 dbg_state
);

  localparam int NW_L  = byte_count(KS);
  localparam int NP_L  = byte_count(IMG);
  localparam int CNT_W = cnt_bits(NW_L, NP_L);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] W_LAST  = CNT_W'(NW_L - 1);
  localparam logic [CNT_W-1:0] P_LAST  = CNT_W'(NP_L - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             xfer;

  assign in_ready  = (state != PRESENT);
  assign out_valid = (state == PRESENT);
  assign xfer      = in_valid && in_ready;
  assign dbg_state = state;

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD_W:  if (xfer && cnt == W_LAST) state_nxt = LOAD_F;
      LOAD_F:  if (xfer && cnt == P_LAST) state_nxt = PRESENT;
      PRESENT: if (out_ready) state_nxt = reload_w ? LOAD_W : LOAD_F;
      default: state_nxt = LOAD_W;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LOAD_W;
      cnt      <= '0;
      f        <= '0;
      w        <= '0;
      w_loaded <= 1'b0;
    end else begin
      state <= state_nxt;
      // Counter restarts on every phase change, so the last byte of one phase
      // and the first byte of the next can go on consecutive edges.
      if (state_nxt != state)
        cnt <= '0;
      else if (xfer)
        cnt <= cnt + CNT_ONE;

      if (xfer && state == LOAD_W) begin
        w[(NW_L - 1 - int'(cnt)) * PIX_W +: PIX_W] <= in_data;
        if (cnt == W_LAST) w_loaded <= 1'b1;
      end
      if (xfer && state == LOAD_F)
        f[int'(cnt) * PIX_W +: PIX_W] <= in_data;
    end
  end

endmodule

// File: doc/conv_frame_loader.md
CONV_FRAME_LOADER -- requirements
Module: conv_frame_loader

Interface
REQ-001 SHALL have parameter PIX_W, default 8, meaning pixel/weight byte width.
REQ-002 SHALL have parameter IMG, default 5, meaning image side length (IMG*IMG pixels).
REQ-003 SHALL have parameter KS, default 3, meaning kernel side length (KS*KS weights).
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, meaning reset, synchronous and active-high.
REQ-006 SHALL have port in_data, input, PIX_W, meaning the byte stream: weights first, then pixels.
REQ-007 SHALL have port in_valid, input, 1, meaning in_data is valid.
REQ-008 SHALL have port in_ready, output, 1, meaning the loader accepts in_data this cycle.
REQ-009 SHALL have port reload_w, input, 1, meaning a new kernel precedes the next frame.
REQ-010 SHALL have port f, output, IMG*IMG*PIX_W (200), meaning the packed image.
REQ-011 SHALL have port w, output, KS*KS*PIX_W (72), meaning the packed kernel.
REQ-012 SHALL have port out_valid, output, 1, meaning f and w are complete and stable.
REQ-013 SHALL have port out_ready, input, 1, meaning the convolution stage has consumed f/w.
REQ-014 SHALL have port w_loaded, output, 1, meaning a kernel has been captured since reset.

Function
REQ-015 SHALL count a byte as transferred only when in_valid and in_ready are both 1 on a rising clk edge.
REQ-016 SHALL implement the states LOAD_W, LOAD_F and PRESENT.
REQ-017 SHALL assert in_ready=1 in LOAD_W and LOAD_F and in_ready=0 in PRESENT.
REQ-018 SHALL pack weight k (raster order, k=0 top-left) into w[(KS*KS-1-k)*PIX_W +: PIX_W], so weight 0 lands in w[71:64].
REQ-019 SHALL pack pixel k (raster order, k=0 top-left) into f[k*PIX_W +: PIX_W], so pixel 0 lands in f[7:0].
REQ-020 SHALL use one shared byte index counter, cleared on every state entry, that advances by 1 per transfer.
REQ-021 SHALL move from LOAD_W to LOAD_F, and set w_loaded=1, on the transfer of weight KS*KS-1.
REQ-022 SHALL move from LOAD_F to PRESENT on the transfer of pixel IMG*IMG-1, and SHALL assert out_valid=1 on the next cycle.
REQ-023 SHALL hold out_valid, f and w constant while in PRESENT until out_ready=1 is sampled.
REQ-024 SHALL, on the out_ready handshake, deassert out_valid and go to LOAD_W if reload_w=1 in that cycle, otherwise to LOAD_F.
REQ-025 SHALL ignore out_ready outside PRESENT.
REQ-026 SHALL sample reload_w only at the PRESENT exit handshake.
REQ-027 SHALL hold the previous kernel in w during LOAD_F, so a frame may reuse the kernel.
REQ-028 SHALL hold each f byte at its old value until that byte is overwritten.
REQ-029 SHALL allow in_valid gaps of any length without losing or duplicating a byte.
REQ-030 SHALL have zero bubble between weight phase and pixel phase: weight KS*KS-1 and pixel 0 may transfer on consecutive cycles.

Reset
REQ-031 SHALL, with rst=1 at a clk edge, set state=LOAD_W, counter=0, out_valid=0, w_loaded=0, f=0 and w=0.
REQ-032 SHALL give rst priority over every transfer and handshake in the same cycle.
REQ-033 SHALL, when rst is applied mid-load or in PRESENT, discard the partial frame and restart with a weight load.

Structure
REQ-034 SHALL place the state encoding and the byte counts NW=KS*KS and NP=IMG*IMG in a shared package, conv_pkg.
REQ-035 SHALL be a single flat module with no sub-modules.

Verification
REQ-036 SHALL cover this scenario: after reset, stream weights 1..9, then pixels 1..25 with continuous in_valid -> out_valid rises one cycle after byte 34, w=0x010203040506070809, f[7:0]=0x01, f[199:192]=0x19.
REQ-037 SHALL cover this scenario: out_ready held 0 for 10 cycles with in_valid=1 -> in_ready=0 throughout, f/w unchanged, no byte consumed.
REQ-038 SHALL cover this scenario: handshake with reload_w=0, then 25 pixels of value 0xFF -> w still 0x010203040506070809 and f all 0xFF.
REQ-039 SHALL cover this scenario: in_valid toggling 1/0 each cycle through a full load -> packing identical to REQ-036, out_valid after the 34th transfer.
REQ-040 SHALL cover this scenario: rst asserted after pixel 12 -> out_valid=0, w_loaded=0, f=0, w=0, and the next 9 bytes are taken as weights.
REQ-041 SHALL cover this scenario: rst and out_ready both 1 in PRESENT -> reset wins, state=LOAD_W.
